// File: rtl/cplx_dsp_pkg.sv
// Shared types, default widths and the round-half-up shift used by the complex dump decimator.
package cplx_dsp_pkg;

  localparam int IWIDTH_DEF = 35;
  localparam int OWIDTH_DEF = 16;
  localparam int DWIDTH_DEF = 8;
  localparam int SWIDTH_DEF = 6;
  localparam int ACC_W      = IWIDTH_DEF + DWIDTH_DEF;
  // Working width for scaling: holds any accumulator plus the rounding carry.
  localparam int RS_W       = 64;

  typedef struct packed {
    logic signed [OWIDTH_DEF-1:0] re;
    logic signed [OWIDTH_DEF-1:0] im;
  } cplx_t;

  function automatic logic signed [RS_W-1:0] round_shift(input logic signed [RS_W-1:0] v,
                                                         input int unsigned s);
    if (s == 0) return v;
    return (v + (RS_W'(1) <<< (s - 1))) >>> s;
  endfunction

endpackage

// File: rtl/cplx_round_sat.sv
// One output rail: round-half-up right shift, then clamp (CPLX_DUMP_DECIM_SAT_EN) or wrap to OW bits.
module cplx_round_sat
  import cplx_dsp_pkg::*;
#(
  parameter int IW = ACC_W,
  parameter int OW = OWIDTH_DEF,
  parameter int SW = SWIDTH_DEF
) (
  input  logic signed [IW-1:0] din,
  input  logic        [SW-1:0] shift,
  output logic signed [OW-1:0] dout,
  output logic                 sat
);

  logic signed [RS_W-1:0] scaled;

  assign scaled = round_shift(RS_W'(din), 32'(shift));

`ifdef CPLX_DUMP_DECIM_SAT_EN
  localparam logic signed [RS_W-1:0] MAXV = (RS_W'(1) <<< (OW - 1)) - RS_W'(1);
  localparam logic signed [RS_W-1:0] MINV = -(RS_W'(1) <<< (OW - 1));

  // Returns {clamped, value}.
  function automatic logic [OW:0] clamp(input logic signed [RS_W-1:0] v);
    if (v > MAXV) return {1'b1, MAXV[OW-1:0]};
    if (v < MINV) return {1'b1, MINV[OW-1:0]};
    return {1'b0, v[OW-1:0]};
  endfunction

  assign {sat, dout} = clamp(scaled);
`else
  logic unused_hi;

  assign dout      = scaled[OW-1:0];
  assign sat       = 1'b0;
  assign unused_hi = ^scaled[RS_W-1:OW];
`endif

endmodule

// File: rtl/cplx_dump_decim.sv
// Complex integrate-and-dump decimator with 2-entry output buffer.
// Define CPLX_DUMP_DECIM_SAT_EN to saturate output rails instead of wrapping.
module cplx_dump_decim
  import cplx_dsp_pkg::*;
#(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int OWIDTH = OWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int SWIDTH = SWIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic        [DWIDTH-1:0] decim,
  input  logic        [SWIDTH-1:0] shift,
  input  logic                     clr_flags,
  input  logic                     in_valid,
  input  logic signed [IWIDTH-1:0] in_re,
  input  logic signed [IWIDTH-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OWIDTH-1:0] out_re,
  output logic signed [OWIDTH-1:0] out_im,
  output logic                     overflow,
  output logic                     sat_flag
);

  localparam int AW = IWIDTH + DWIDTH;

  typedef struct packed {
    logic signed [OWIDTH-1:0] re;
    logic signed [OWIDTH-1:0] im;
  } samp_t;

  // Stage p0: input capture
  logic                     vld_p0;
  logic signed [IWIDTH-1:0] re_p0, im_p0;
  logic        [DWIDTH-1:0] decim_p0;
  logic        [SWIDTH-1:0] shift_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    re_p0    <= in_re;
    im_p0    <= in_im;
    decim_p0 <= decim;
    shift_p0 <= shift;
  end

  // Stage p1: accumulate, dump full sum into stage register
  logic        [DWIDTH-1:0] count, n_q, n_eff;
  logic        [SWIDTH-1:0] s_q, s_eff;
  logic signed [AW-1:0]     acc_re, acc_im, base_re, base_im, sum_re, sum_im;
  logic signed [AW-1:0]     stage_re, stage_im;
  logic        [SWIDTH-1:0] stage_s;
  logic                     vld_p1, first, last;

  always_comb begin
    first   = (count == '0);
    n_eff   = first ? ((decim_p0 == '0) ? DWIDTH'(1) : decim_p0) : n_q;
    s_eff   = first ? shift_p0 : s_q;
    last    = (count == n_eff - DWIDTH'(1));
    base_re = first ? AW'(0) : acc_re;
    base_im = first ? AW'(0) : acc_im;
    sum_re  = base_re + AW'(re_p0);
    sum_im  = base_im + AW'(im_p0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      n_q      <= '0;
      s_q      <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      stage_re <= '0;
      stage_im <= '0;
      stage_s  <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (vld_p0) begin
        if (first) begin
          n_q <= n_eff;
          s_q <= shift_p0;
        end
        if (last) begin
          stage_re <= sum_re;
          stage_im <= sum_im;
          stage_s  <= s_eff;
          vld_p1   <= 1'b1;
          count    <= '0;
        end else begin
          acc_re <= sum_re;
          acc_im <= sum_im;
          count  <= count + DWIDTH'(1);
        end
      end
    end
  end

  // Stage p2: scale each rail and push into the output buffer
  logic signed [OWIDTH-1:0] sc_re, sc_im;
  logic                     sat_re, sat_im;

  cplx_round_sat #(.IW(AW), .OW(OWIDTH), .SW(SWIDTH)) u_rs_re (
    .din(stage_re), .shift(stage_s), .dout(sc_re), .sat(sat_re)
  );
  cplx_round_sat #(.IW(AW), .OW(OWIDTH), .SW(SWIDTH)) u_rs_im (
    .din(stage_im), .shift(stage_s), .dout(sc_im), .sat(sat_im)
  );

  samp_t       mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  fcnt;
  logic        pop, full, push_ok;

  always_comb begin
    pop     = (fcnt != 2'd0) && out_ready;
    full    = (fcnt == 2'd2);
    push_ok = vld_p1 && (!full || pop);
    // With two slots, the write slot is the head when empty or full, else the other one.
    wr_ptr  = rd_ptr ^ fcnt[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr   <= 1'b0;
      fcnt     <= 2'd0;
      overflow <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (push_ok) mem[wr_ptr] <= '{re: sc_re, im: sc_im};
      if (pop)     rd_ptr <= ~rd_ptr;
      fcnt <= fcnt + 2'(push_ok) - 2'(pop);
      if (vld_p1 && full && !pop) overflow <= 1'b1;
      else if (clr_flags)         overflow <= 1'b0;
      if (vld_p1 && (sat_re || sat_im)) sat_flag <= 1'b1;
      else if (clr_flags)               sat_flag <= 1'b0;
    end
  end

  assign out_valid = (fcnt != 2'd0);
  assign out_re    = mem[rd_ptr].re;
  assign out_im    = mem[rd_ptr].im;

endmodule

// File: tb/tb_cplx_dump_decim.sv
// Directed bench for cplx_dump_decim with a cycle-level behavioural model and literal spot checks.
module tb_cplx_dump_decim;

  localparam int IW = 35;
  localparam int OW = 16;
  localparam int DW = 8;
  localparam int SW = 6;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic        [DW-1:0] decim = 8'd1;
  logic        [SW-1:0] shift = '0;
  logic                 clr_flags = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [IW-1:0] in_re = '0;
  logic signed [IW-1:0] in_im = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [OW-1:0] out_re, out_im;
  logic                 overflow, sat_flag;

  cplx_dump_decim #(.IWIDTH(IW), .OWIDTH(OW), .DWIDTH(DW), .SWIDTH(SW)) dut (
    .clk(clk), .rst(rst), .decim(decim), .shift(shift), .clr_flags(clr_flags),
    .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .overflow(overflow), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint re;
    longint im;
    bit     sat;
    int     due;
  } item_t;

  item_t  pipe[$];
  item_t  mb[$];
  longint log_re[$];
  longint log_im[$];
  bit     e_ovf = 0, e_sat = 0;
  int     cyc = 0;
  int     m_cnt = 0, m_n = 1, m_s = 0;
  longint m_re = 0, m_im = 0;

  function automatic longint scale_clip(input longint v, input int s, output bit sat);
    longint q, lim, r;
    q   = v;
    if (s > 0) q = (v + (longint'(1) << (s - 1))) >>> s;
    lim = longint'(1) << (OW - 1);
    sat = 1'b0;
`ifdef CPLX_DUMP_DECIM_SAT_EN
    r = q;
    if (q > lim - 1) begin r = lim - 1; sat = 1'b1; end
    if (q < -lim)    begin r = -lim;    sat = 1'b1; end
`else
    r = q & (2 * lim - 1);
    if (r >= lim) r = r - 2 * lim;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    item_t it;
    bit    s1, s2, pop;
    cyc++;
    if (rst) begin
      m_cnt = 0;
      pipe.delete();
      mb.delete();
      e_ovf = 0;
      e_sat = 0;
    end else begin
      pop = (mb.size() > 0) && out_ready;
      if (pop) begin
        log_re.push_back(longint'(out_re));
        log_im.push_back(longint'(out_im));
        void'(mb.pop_front());
      end
      if (clr_flags) begin e_ovf = 0; e_sat = 0; end
      if (pipe.size() > 0 && pipe[0].due == cyc) begin
        it = pipe.pop_front();
        if (it.sat) e_sat = 1;
        if (mb.size() == 2) e_ovf = 1;
        else                mb.push_back(it);
      end
      if (in_valid) begin
        if (m_cnt == 0) begin
          m_n  = (decim == 0) ? 1 : int'(decim);
          m_s  = int'(shift);
          m_re = 0;
          m_im = 0;
        end
        m_re += longint'(in_re);
        m_im += longint'(in_im);
        m_cnt++;
        if (m_cnt == m_n) begin
          it.re  = scale_clip(m_re, m_s, s1);
          it.im  = scale_clip(m_im, m_s, s2);
          it.sat = s1 | s2;
          it.due = cyc + 2;
          pipe.push_back(it);
          m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, mb.size() > 0);
      if (mb.size() > 0) begin
        chk("out_re", out_re, mb[0].re);
        chk("out_im", out_im, mb[0].im);
      end
      chk("overflow", overflow, e_ovf);
      chk("sat_flag", sat_flag, e_sat);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input longint re, input longint im);
    @(negedge clk);
    in_valid = 1'b1;
    in_re    = IW'(re);
    in_im    = IW'(im);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic clear_log();
    log_re.delete();
    log_im.delete();
  endtask

  initial begin
    #1_000_000;
    compared++;
    mismatched++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sat_flag", sat_flag, 0);

    // 1: N=4, latency and steady-rate dumps
    decim = 8'd4; shift = '0; clear_log();
    repeat (4) send(1, -1);
    @(negedge clk); in_valid = 1'b0;
    chk("t1_lat_t", out_valid, 0);
    @(negedge clk);
    chk("t1_lat_t1", out_valid, 0);
    @(negedge clk);
    chk("t1_lat_t2", out_valid, 1);
    repeat (4) send(1, -1);
    idle(5);
    chk("t1_count", log_re.size(), 2);
    if (log_re.size() == 2) begin
      chk("t1_re0", log_re[0], 4);  chk("t1_im0", log_im[0], -4);
      chk("t1_re1", log_re[1], 4);  chk("t1_im1", log_im[1], -4);
    end

    // 2: N=1, shift=2 rounding
    decim = 8'd1; shift = 6'd2; clear_log();
    send(6, 0);
    send(-6, 0);
    idle(5);
    chk("t2_count", log_re.size(), 2);
    if (log_re.size() == 2) begin
      chk("t2_re0", log_re[0], 2);
      chk("t2_re1", log_re[1], -1);
    end

    // 3: saturation or wrap of 40000
    decim = 8'd2; shift = '0; clear_log();
    send(20000, 0);
    send(20000, 0);
    idle(5);
    chk("t3_count", log_re.size(), 1);
`ifdef CPLX_DUMP_DECIM_SAT_EN
    if (log_re.size() == 1) chk("t3_re", log_re[0], 32767);
    chk("t3_sat", sat_flag, 1);
`else
    if (log_re.size() == 1) chk("t3_re", log_re[0], -25536);
    chk("t3_sat", sat_flag, 0);
`endif
    @(negedge clk); clr_flags = 1'b1;
    @(negedge clk); clr_flags = 1'b0;
    chk("t3_sat_clr", sat_flag, 0);

    // 4: buffer full, third dump dropped
    decim = 8'd1; out_ready = 1'b0; clear_log();
    send(10, 1);
    send(20, 2);
    send(30, 3);
    idle(4);
    chk("t4_overflow", overflow, 1);
    chk("t4_valid", out_valid, 1);
    chk("t4_head", out_re, 10);
    @(negedge clk); out_ready = 1'b1;
    idle(4);
    chk("t4_count", log_re.size(), 2);
    if (log_re.size() == 2) begin
      chk("t4_re0", log_re[0], 10); chk("t4_im0", log_im[0], 1);
      chk("t4_re1", log_re[1], 20); chk("t4_im1", log_im[1], 2);
    end
    chk("t4_empty", out_valid, 0);

    // 5: reset mid-period discards partial sum
    decim = 8'd8; clear_log();
    repeat (5) send(100, 100);
    idle(1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t5_valid", out_valid, 0);
    chk("t5_overflow", overflow, 0);
    chk("t5_sat", sat_flag, 0);
    for (int i = 1; i <= 8; i++) send(i, -2 * i);
    idle(5);
    chk("t5_count", log_re.size(), 1);
    if (log_re.size() == 1) begin
      chk("t5_re", log_re[0], 36);
      chk("t5_im", log_im[0], -72);
    end

    // 6: ratio change mid-period with gaps
    decim = 8'd4; clear_log();
    send(1, 0);
    idle(1);
    send(2, 0);
    decim = 8'd2;
    send(3, 0);
    idle(2);
    send(4, 0);
    send(5, 0);
    idle(1);
    send(6, 0);
    send(7, 0);
    send(8, 0);
    idle(5);
    chk("t6_count", log_re.size(), 3);
    if (log_re.size() == 3) begin
      chk("t6_re0", log_re[0], 10);
      chk("t6_re1", log_re[1], 11);
      chk("t6_re2", log_re[2], 15);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
